// File: rtl/fir_decim_acc.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_acc
// Description : Sums N consecutive valid samples and emits one widened sum per
//               window; sync restarts the window, ratio re-latches at bounds.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_acc #(
   parameter int DATA_WIDTH = 16,
   parameter int RATIO_W    = 8,
   parameter int OUT_WIDTH  = DATA_WIDTH + RATIO_W
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         cfg_en_i,
   input  logic [RATIO_W-1:0]           cfg_ratio_i,
   input  logic                         src_valid_i,
   input  logic signed [DATA_WIDTH-1:0] src_data_i,
   input  logic                         src_sync_i,
   output logic                         acc_valid_o,
   output logic signed [OUT_WIDTH-1:0]  acc_data_o,
   output logic [RATIO_W-1:0]           acc_cnt_o,
   output logic                         busy_o
);

   localparam logic [RATIO_W-1:0] c_ONE = {{(RATIO_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   state_t                       r_state;
   state_t                       w_state_next;
   logic [RATIO_W-1:0]           r_ratio;
   logic [RATIO_W-1:0]           r_cnt;
   logic signed [OUT_WIDTH-1:0]  r_acc;
   logic signed [OUT_WIDTH-1:0]  r_data;
   logic                         r_valid;

   logic [RATIO_W-1:0]           w_ratio_cfg;
   logic signed [OUT_WIDTH-1:0]  w_sample_ext;
   logic signed [OUT_WIDTH-1:0]  w_acc_next;
   logic                         w_last;

   // A programmed ratio of zero behaves as a ratio of one.
   assign w_ratio_cfg  = (cfg_ratio_i == '0) ? c_ONE : cfg_ratio_i;
   assign w_sample_ext = {{(OUT_WIDTH-DATA_WIDTH){src_data_i[DATA_WIDTH-1]}}, src_data_i};
   assign w_acc_next   = r_acc + w_sample_ext;
   assign w_last       = (r_cnt == (r_ratio - c_ONE));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (cfg_en_i)  w_state_next = ST_ACC;
         ST_ACC:  if (!cfg_en_i) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ratio <= c_ONE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_en_i) begin
                  r_ratio <= w_ratio_cfg;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_ACC: begin
               if (!cfg_en_i) begin
                  r_acc <= '0;
                  r_cnt <= '0;
               end else if (src_sync_i) begin
                  // Sync wins over a completing sample; the new window may start here.
                  r_ratio <= w_ratio_cfg;
                  if (src_valid_i && (w_ratio_cfg == c_ONE)) begin
                     r_data  <= w_sample_ext;
                     r_valid <= 1'b1;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                  end else if (src_valid_i) begin
                     r_acc <= w_sample_ext;
                     r_cnt <= c_ONE;
                  end else begin
                     r_acc <= '0;
                     r_cnt <= '0;
                  end
               end else if (src_valid_i) begin
                  if (w_last) begin
                     r_data  <= w_acc_next;
                     r_valid <= 1'b1;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_ratio <= w_ratio_cfg;
                  end else begin
                     r_acc <= w_acc_next;
                     r_cnt <= r_cnt + c_ONE;
                  end
               end
            end
            default: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign acc_valid_o = r_valid;
   assign acc_data_o  = r_data;
   assign acc_cnt_o   = r_cnt;
   assign busy_o      = (r_state == ST_ACC);

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_acc
// Description : Table vectors, directed corner sequences and random stimulus
//               checked against a window-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_acc;

   localparam int DATA_WIDTH = 16;
   localparam int RATIO_W    = 8;
   localparam int OUT_WIDTH  = DATA_WIDTH + RATIO_W;

   logic                         clk;
   logic                         rst_n;
   logic                         cfg_en;
   logic [RATIO_W-1:0]           cfg_ratio;
   logic                         src_valid;
   logic signed [DATA_WIDTH-1:0] src_data;
   logic                         src_sync;
   logic                         acc_valid;
   logic signed [OUT_WIDTH-1:0]  acc_data;
   logic [RATIO_W-1:0]           acc_cnt;
   logic                         busy;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: the current window is a list of accepted samples.
   bit      m_en;
   int      m_ratio;
   longint  m_win[$];
   longint  m_data;
   bit      m_pulse;

   fir_decim_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .RATIO_W    (RATIO_W),
      .OUT_WIDTH  (OUT_WIDTH)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cfg_en_i    (cfg_en),
      .cfg_ratio_i (cfg_ratio),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .src_sync_i  (src_sync),
      .acc_valid_o (acc_valid),
      .acc_data_o  (acc_data),
      .acc_cnt_o   (acc_cnt),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_en    = 1'b0;
      m_ratio = 1;
      m_win.delete();
      m_data  = 0;
      m_pulse = 1'b0;
   endfunction

   function automatic void model_step(input bit en, input int ratio, input bit valid,
                                      input int data, input bit sync);
      int     rc;
      longint s;
      rc      = (ratio == 0) ? 1 : ratio;
      m_pulse = 1'b0;
      if (!m_en) begin
         if (en) begin
            m_en    = 1'b1;
            m_ratio = rc;
            m_win.delete();
         end
      end else if (!en) begin
         m_en = 1'b0;
         m_win.delete();
      end else begin
         if (sync) begin
            m_win.delete();
            m_ratio = rc;
         end
         if (valid) begin
            m_win.push_back(longint'(data));
            if (m_win.size() == m_ratio) begin
               s = 0;
               foreach (m_win[k]) s += m_win[k];
               m_data  = s;
               m_pulse = 1'b1;
               m_win.delete();
               m_ratio = rc;
            end
         end
      end
   endfunction

   // One clock: drive, advance, update model, compare all outputs.
   task automatic cycle(input bit en, input int ratio, input bit valid,
                        input int data, input bit sync);
      cfg_en    = en;
      cfg_ratio = RATIO_W'(ratio);
      src_valid = valid;
      src_data  = DATA_WIDTH'(data);
      src_sync  = sync;
      @(posedge clk);
      model_step(en, ratio, valid, data, sync);
      #1;
      check("m_valid", longint'(acc_valid), longint'(m_pulse));
      check("m_data",  longint'(acc_data),  m_data);
      check("m_cnt",   longint'(acc_cnt),   longint'(m_win.size()));
      check("m_busy",  longint'(busy),      longint'(m_en));
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      cfg_en    = 1'b0;
      src_valid = 1'b0;
      src_sync  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid", longint'(acc_valid), 0);
      check("rst_data",  longint'(acc_data),  0);
      check("rst_cnt",   longint'(acc_cnt),   0);
      check("rst_busy",  longint'(busy),      0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit en;
      int ratio;
      bit valid;
      int data;
      bit sync;
      bit e_vld;
      int e_data;
      int e_cnt;
      bit e_busy;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst_n     = 1'b1;
      cfg_en    = 1'b0;
      cfg_ratio = '0;
      src_valid = 1'b0;
      src_data  = '0;
      src_sync  = 1'b0;
      model_reset();
      do_reset();

      // N=4 sums 10 and 26, then full-scale negative and positive windows.
      tbl.push_back('{1, 4, 0, 0, 0,  0, 0, 0, 1});
      tbl.push_back('{1, 4, 1, 1, 0,  0, 0, 1, 1});
      tbl.push_back('{1, 4, 1, 2, 0,  0, 0, 2, 1});
      tbl.push_back('{1, 4, 1, 3, 0,  0, 0, 3, 1});
      tbl.push_back('{1, 4, 1, 4, 0,  1, 10, 0, 1});
      tbl.push_back('{1, 4, 1, 5, 0,  0, 10, 1, 1});
      tbl.push_back('{1, 4, 1, 6, 0,  0, 10, 2, 1});
      tbl.push_back('{1, 4, 1, 7, 0,  0, 10, 3, 1});
      tbl.push_back('{1, 4, 1, 8, 0,  1, 26, 0, 1});
      tbl.push_back('{1, 4, 0, 0, 0,  0, 26, 0, 1});
      tbl.push_back('{1, 4, 1, -32768, 0,  0, 26, 1, 1});
      tbl.push_back('{1, 4, 1, -32768, 0,  0, 26, 2, 1});
      tbl.push_back('{1, 4, 1, -32768, 0,  0, 26, 3, 1});
      tbl.push_back('{1, 4, 1, -32768, 0,  1, -131072, 0, 1});
      tbl.push_back('{1, 4, 1, 32767, 0,  0, -131072, 1, 1});
      tbl.push_back('{1, 4, 1, 32767, 0,  0, -131072, 2, 1});
      tbl.push_back('{1, 4, 1, 32767, 0,  0, -131072, 3, 1});
      tbl.push_back('{1, 4, 1, 32767, 0,  1, 131068, 0, 1});

      foreach (tbl[i]) begin
         cycle(tbl[i].en, tbl[i].ratio, tbl[i].valid, tbl[i].data, tbl[i].sync);
         check("tbl_valid", longint'(acc_valid), longint'(tbl[i].e_vld));
         check("tbl_data",  longint'(acc_data),  longint'(tbl[i].e_data));
         check("tbl_cnt",   longint'(acc_cnt),   longint'(tbl[i].e_cnt));
         check("tbl_busy",  longint'(busy),      longint'(tbl[i].e_busy));
      end

      // N=3 with gaps in valid.
      do_reset();
      cycle(1, 3, 0, 0, 0);
      cycle(1, 3, 1, 5, 0);
      cycle(1, 3, 0, 99, 0);
      check("gap_cnt_hold", longint'(acc_cnt), 1);
      cycle(1, 3, 0, 99, 0);
      cycle(1, 3, 1, 6, 0);
      cycle(1, 3, 1, 7, 0);
      check("gap_pulse", longint'(acc_valid), 1);
      check("gap_sum",   longint'(acc_data),  18);
      cycle(1, 3, 0, 0, 0);
      cycle(1, 3, 1, 9, 0);
      check("gap_next_cnt", longint'(acc_cnt), 1);

      // Sync restarts the window with its own sample.
      do_reset();
      cycle(1, 4, 0, 0, 0);
      cycle(1, 4, 1, 3, 0);
      cycle(1, 4, 1, 4, 0);
      cycle(1, 4, 1, 10, 1);
      check("sync_no_pulse", longint'(acc_valid), 0);
      check("sync_cnt",      longint'(acc_cnt),   1);
      cycle(1, 4, 1, 1, 0);
      cycle(1, 4, 1, 1, 0);
      cycle(1, 4, 1, 1, 0);
      check("sync_sum", longint'(acc_data), 13);

      // Sync on a window-completing sample suppresses the pulse.
      cycle(1, 2, 1, 5, 0);
      cycle(1, 2, 1, 6, 0);
      cycle(1, 2, 1, 7, 0);
      cycle(1, 2, 1, 8, 1);
      check("sync_wins", longint'(acc_valid), 0);

      // Ratio changes apply only at window boundaries; ratio 0 acts as 1.
      do_reset();
      cycle(1, 2, 0, 0, 0);
      cycle(1, 2, 1, 3, 0);
      cycle(1, 5, 1, 4, 0);
      check("ratio_old_sum", longint'(acc_data), 7);
      for (int k = 1; k <= 4; k++) cycle(1, 5, 1, k, 0);
      check("ratio_new_cnt", longint'(acc_cnt), 4);
      cycle(1, 0, 1, 5, 0);
      check("ratio5_sum", longint'(acc_data), 15);
      cycle(1, 0, 1, -7, 0);
      check("ratio0_a", longint'(acc_data), -7);
      cycle(1, 0, 1, 100, 0);
      check("ratio0_b_vld", longint'(acc_valid), 1);
      check("ratio0_b", longint'(acc_data), 100);

      // Disable mid-window, then asynchronous reset mid-window.
      do_reset();
      cycle(1, 4, 0, 0, 0);
      for (int k = 0; k < 4; k++) cycle(1, 4, 1, 1, 0);
      cycle(1, 4, 1, 7, 0);
      cycle(1, 4, 1, 7, 0);
      cycle(0, 4, 1, 7, 0);
      check("dis_busy", longint'(busy),      0);
      check("dis_vld",  longint'(acc_valid), 0);
      check("dis_hold", longint'(acc_data),  4);
      cycle(0, 4, 1, 7, 0);
      cycle(1, 4, 0, 0, 0);
      cycle(1, 4, 1, 9, 0);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 6));
         cycle(($urandom_range(0, 99) != 0), r,
               ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 65535)) - 32768,
               ($urandom_range(0, 31) == 0));
         if (n == 1000) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_decim_acc.md
Name: fir_decim_acc

Overview:
Sample accumulator and decimator placed directly downstream of the fir_ctrl register-delay alignment stage. It consumes the aligned signed sample stream with valid, sums N consecutive valid samples (N is runtime-programmable), and emits one widened sum per N inputs. A sync input restarts the accumulation window at line or trigger boundaries. The output feeds the FIR/packing logic.

Parameters:
DATA_WIDTH, 16, width of signed input sample
RATIO_W, 8, width of the decimation-ratio field; max ratio 2^RATIO_W-1
OUT_WIDTH, DATA_WIDTH+RATIO_W, width of signed sum output; must be >= DATA_WIDTH+RATIO_W

Ports:
clk_i  in  1  single clock for all logic
rst_n_i  in  1  reset, asynchronous assert, active-low
cfg_en_i  in  1  block enable; low forces IDLE
cfg_ratio_i  in  RATIO_W  decimation ratio N; 0 is treated as 1
src_valid_i  in  1  input sample valid
src_data_i  in  DATA_WIDTH  signed two's-complement sample
src_sync_i  in  1  window restart, sampled every cycle
acc_valid_o  out  1  one-cycle pulse, sum valid
acc_data_o  out  OUT_WIDTH  signed sum of the last N samples, held between pulses
acc_cnt_o  out  RATIO_W  samples accumulated in the current window
busy_o  out  1  high in state ACC

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE. acc_valid_o=0, acc_data_o=0, acc_cnt_o=0, busy_o=0. Internal accumulator=0, latched ratio=1.
- FSM has two states.
  - IDLE: move to ACC when cfg_en_i=1. On entry, latch ratio_r = (cfg_ratio_i==0 ? 1 : cfg_ratio_i), acc=0, cnt=0.
  - ACC: return to IDLE when cfg_en_i=0. This discards the partial sum and emits no pulse. acc_data_o keeps its last value.
- Accumulation, in ACC with src_valid_i=1:
  - acc_next = acc + sign_extend(src_data_i), computed at OUT_WIDTH bits. No saturation is needed because the width covers the worst case.
  - If cnt == ratio_r-1, this sample completes the window:
    - acc_data_o <= acc_next and acc_valid_o <= 1 on the next edge. Latency is 1 clk from the last accepted sample to the pulse.
    - acc <= 0 and cnt <= 0.
    - ratio_r re-latches from cfg_ratio_i. Ratio changes take effect only at window boundaries.
  - Otherwise acc <= acc_next and cnt <= cnt+1.
- src_valid_i=0: acc and cnt hold. Gaps of any length are allowed.
- acc_valid_o is a single-cycle pulse and is 0 in all other cycles. Back-to-back pulses occur every cycle when N=1 and valid is continuous.
- src_sync_i=1 in ACC discards the partial window: acc and cnt clear and ratio_r re-latches.
  - If src_valid_i=1 in the same cycle, that sample is the first of the new window: acc=sample, cnt=1, or an immediate emit if the new ratio is 1.
  - No pulse is issued for the discarded partial window.
- src_sync_i coinciding with a window-completing sample: sync wins. The partial sum is discarded and no pulse is issued.
- Inputs are ignored in IDLE.
- acc_cnt_o = cnt, registered. busy_o = (state==ACC).
- Reset asserted mid-window clears everything immediately. After release, the FSM resumes from IDLE.

Test Plan:
1. Reset, then cfg_en=1, N=4, continuous valid with samples 1,2,3,4,5,6,7,8 -> pulses carrying sums 10 and 26, each one cycle after samples 4 and 8. Pulse spacing is 4 clk.
2. N=4, samples -32768 ×4 with DATA_WIDTH=16 -> acc_data_o = -131072, correctly sign-extended. Then 32767 ×4 -> 131068.
3. N=3, valid toggling 1,0,0,1,1,0,1 with samples 5,x,x,6,7,x,9 -> one pulse with value 18 after the third valid sample. The zero-valid cycles leave acc_cnt_o unchanged.
4. N=4: feed 2 samples, then assert sync together with sample 10, then feed 3 more samples of 1 -> the first partial is discarded and one pulse carries 13.
5. N=2, then cfg_ratio changes to 5 mid-window -> the current window still closes after 2 samples. The next window needs 5 samples. cfg_ratio=0 gives a pulse for every sample, each equal to that sample.
6. Drop cfg_en mid-window -> no pulse, busy_o=0, acc_data_o holds its previous value. Assert rst_n_i low mid-window -> all outputs go to 0 with no clock edge needed.
